// File: rtl/legv8_dmem_bridge.sv
// Bridges the LEGv8 single-cycle datapath's 64-bit data-memory port onto a 32-bit req/ack bus.
// Each access becomes two little-endian beats; the datapath is stalled until the access completes.
module legv8_dmem_bridge #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [63:0]       iAddress,
    input  logic [63:0]       iWriteData,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    output logic [63:0]       oReadData,
    output logic              oStall,
    output logic              oFault,
    output logic              oBusReq,
    output logic              oBusWe,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [31:0]       oBusWData,
    input  logic              iBusAck,
    input  logic [31:0]       iBusRData
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e            stateQ, stateD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [63:0]       wdataQ, wdataD;
    logic              weQ, weD;
    logic [31:0]       rdLoQ, rdLoD;
    logic              abortQ, abortD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [63:0]       readDataQ, readDataD;

    logic anyReq;
    logic badReq;

    assign anyReq = iMemRead | iMemWrite;
    assign badReq = (iMemRead & iMemWrite) | (iAddress[2:0] != 3'b000) |
                    (iAddress[63:ADDR_W] != '0);

    assign oReadData = readDataQ;

    always_comb begin
        stateD    = stateQ;
        addrD     = addrQ;
        wdataD    = wdataQ;
        weD       = weQ;
        rdLoD     = rdLoQ;
        abortD    = abortQ;
        cntD      = cntQ;
        readDataD = readDataQ;
        oStall    = 1'b0;
        oFault    = 1'b0;
        oBusReq   = 1'b0;
        oBusWe    = 1'b0;
        oBusAddr  = '0;
        oBusWData = '0;

        unique case (stateQ)
            StIdle: begin
                if (anyReq) begin
                    if (badReq) begin
                        oFault = 1'b1;
                    end else begin
                        oStall = 1'b1;
                        addrD  = iAddress[ADDR_W-1:0];
                        wdataD = iWriteData;
                        weD    = iMemWrite;
                        abortD = 1'b0;
                        cntD   = '0;
                        stateD = StLo;
                    end
                end
            end
            StLo: begin
                oStall    = 1'b1;
                oBusReq   = 1'b1;
                oBusWe    = weQ;
                oBusAddr  = addrQ;
                oBusWData = wdataQ[31:0];
                if (iBusAck) begin
                    if (!weQ) begin
                        rdLoD = iBusRData;
                    end
                    cntD   = '0;
                    stateD = StHi;
                end else if (cntQ == CNT_W'(TIMEOUT_CYC - 1)) begin
                    abortD    = 1'b1;
                    readDataD = '0;
                    stateD    = StDone;
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            StHi: begin
                oStall    = 1'b1;
                oBusReq   = 1'b1;
                oBusWe    = weQ;
                oBusAddr  = addrQ + ADDR_W'(4);
                oBusWData = wdataQ[63:32];
                if (iBusAck) begin
                    // Result lands in the register on the DONE edge so it is visible during DONE.
                    if (!weQ) begin
                        readDataD = {iBusRData, rdLoQ};
                    end
                    stateD = StDone;
                end else if (cntQ == CNT_W'(TIMEOUT_CYC - 1)) begin
                    abortD    = 1'b1;
                    readDataD = '0;
                    stateD    = StDone;
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            StDone: begin
                // The request still present here belongs to the instruction now retiring.
                oFault = abortQ;
                abortD = 1'b0;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ    <= StIdle;
            addrQ     <= '0;
            wdataQ    <= '0;
            weQ       <= 1'b0;
            rdLoQ     <= '0;
            abortQ    <= 1'b0;
            cntQ      <= '0;
            readDataQ <= '0;
        end else begin
            stateQ    <= stateD;
            addrQ     <= addrD;
            wdataQ    <= wdataD;
            weQ       <= weD;
            rdLoQ     <= rdLoD;
            abortQ    <= abortD;
            cntQ      <= cntD;
            readDataQ <= readDataD;
        end
    end

endmodule

// File: tb/tb_legv8_dmem_bridge.sv
// Directed bench for legv8_dmem_bridge: a wait-state slave model plus hand-computed expectations.
// Built with TIMEOUT_CYC=4 so the abort path is reachable in a few cycles.
module tb_legv8_dmem_bridge;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [63:0] iAddress = '0;
    logic [63:0] iWriteData = '0;
    logic        iMemRead = 1'b0;
    logic        iMemWrite = 1'b0;
    logic [63:0] oReadData;
    logic        oStall;
    logic        oFault;
    logic        oBusReq;
    logic        oBusWe;
    logic [15:0] oBusAddr;
    logic [31:0] oBusWData;
    logic        iBusAck;
    logic [31:0] iBusRData = '0;

    legv8_dmem_bridge #(
        .ADDR_W      (16),
        .TIMEOUT_CYC (4)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iAddress   (iAddress),
        .iWriteData (iWriteData),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .oReadData  (oReadData),
        .oStall     (oStall),
        .oFault     (oFault),
        .oBusReq    (oBusReq),
        .oBusWe     (oBusWe),
        .oBusAddr   (oBusAddr),
        .oBusWData  (oBusWData),
        .iBusAck    (iBusAck),
        .iBusRData  (iBusRData)
    );

    always #5 iCLK = ~iCLK;

    int nChecks = 0;
    int nPass   = 0;

    // Slave model: acks after waitCyc idle cycles of a beat; strayAck injects unsolicited acks.
    logic        slaveOn  = 1'b1;
    int          waitCyc  = 0;
    logic [31:0] loWord   = '0;
    logic [31:0] hiWord   = '0;
    logic        slaveAck = 1'b0;
    logic        strayAck = 1'b0;
    logic        prevReq  = 1'b0;
    int          sCnt     = 0;

    assign iBusAck = slaveAck | strayAck;

    logic [15:0] logAddr[$];
    logic [31:0] logData[$];
    logic        logWe[$];
    int          reqCycles = 0;

    initial begin
        forever begin
            @(posedge iCLK);
            #2;
            if (!oBusReq) begin
                sCnt     = 0;
                slaveAck = 1'b0;
            end else begin
                if (!prevReq || slaveAck) sCnt = 0;
                else sCnt++;
                slaveAck = slaveOn && (sCnt == waitCyc);
            end
            prevReq   = oBusReq;
            iBusRData = oBusAddr[2] ? hiWord : loWord;
        end
    end

    initial begin
        forever begin
            @(negedge iCLK);
            if (oBusReq) begin
                reqCycles++;
                if (iBusAck) begin
                    logAddr.push_back(oBusAddr);
                    logData.push_back(oBusWData);
                    logWe.push_back(oBusWe);
                end
            end
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clearLog();
        logAddr.delete();
        logData.delete();
        logWe.delete();
    endtask

    // Called at a negedge; returns at the negedge of the cycle after DONE (or after the fault).
    task automatic access(input logic rd, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wd, output int stall, output logic fault,
                          output logic [63:0] rdata);
        iMemRead   = rd;
        iMemWrite  = wr;
        iAddress   = addr;
        iWriteData = wd;
        stall      = 0;
        fault      = 1'b0;
        rdata      = '0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (oFault) fault = 1'b1;
            if (!oStall) begin
                rdata = oReadData;
                break;
            end
            stall++;
            @(negedge iCLK);
        end
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
        @(negedge iCLK);
    endtask

    int          stall;
    logic        fault;
    logic [63:0] rdata;
    int          reqBefore;

    initial begin
        repeat (2) @(negedge iCLK);
        checkVal("reset oStall", 64'(oStall), 64'd0);
        checkVal("reset oBusReq", 64'(oBusReq), 64'd0);
        checkVal("reset oReadData", oReadData, 64'd0);
        checkVal("reset oBusAddr", 64'(oBusAddr), 64'd0);
        iRST = 1'b0;
        @(negedge iCLK);

        // Load, zero-wait slave
        waitCyc = 0; loWord = 32'h89AB_CDEF; hiWord = 32'h0123_4567; clearLog();
        access(1'b1, 1'b0, 64'h10, 64'h0, stall, fault, rdata);
        checkVal("t1 stall", 64'(stall), 64'd3);
        checkVal("t1 rdata", rdata, 64'h0123_4567_89AB_CDEF);
        checkVal("t1 fault", 64'(fault), 64'd0);
        checkVal("t1 nbeats", 64'(logAddr.size()), 64'd2);
        if (logAddr.size() == 2) begin
            checkVal("t1 addr0", 64'(logAddr[0]), 64'h10);
            checkVal("t1 addr1", 64'(logAddr[1]), 64'h14);
        end

        // Store, two wait states per beat
        waitCyc = 2; clearLog();
        access(1'b0, 1'b1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, stall, fault, rdata);
        checkVal("t2 stall", 64'(stall), 64'd7);
        checkVal("t2 rdata held", rdata, 64'h0123_4567_89AB_CDEF);
        checkVal("t2 nbeats", 64'(logAddr.size()), 64'd2);
        if (logAddr.size() == 2) begin
            checkVal("t2 addr0", 64'(logAddr[0]), 64'h20);
            checkVal("t2 data0", 64'(logData[0]), 64'hCAFE_F00D);
            checkVal("t2 we0", 64'(logWe[0]), 64'd1);
            checkVal("t2 addr1", 64'(logAddr[1]), 64'h24);
            checkVal("t2 data1", 64'(logData[1]), 64'hDEAD_BEEF);
            checkVal("t2 we1", 64'(logWe[1]), 64'd1);
        end

        // Rejected requests
        reqBefore = reqCycles;
        access(1'b1, 1'b0, 64'h13, 64'h0, stall, fault, rdata);
        checkVal("t3 misalign fault", 64'(fault), 64'd1);
        checkVal("t3 misalign stall", 64'(stall), 64'd0);
        access(1'b1, 1'b1, 64'h8, 64'h0, stall, fault, rdata);
        checkVal("t3 both fault", 64'(fault), 64'd1);
        checkVal("t3 both stall", 64'(stall), 64'd0);
        access(1'b1, 1'b0, 64'h1_0000, 64'h0, stall, fault, rdata);
        checkVal("t3 range fault", 64'(fault), 64'd1);
        checkVal("t3 no busreq", 64'(reqCycles - reqBefore), 64'd0);

        // Timeout: slave never acks
        slaveOn = 1'b0; clearLog(); reqBefore = reqCycles;
        access(1'b1, 1'b0, 64'h40, 64'h0, stall, fault, rdata);
        checkVal("t4 stall", 64'(stall), 64'd5);
        checkVal("t4 fault", 64'(fault), 64'd1);
        checkVal("t4 rdata", rdata, 64'd0);
        checkVal("t4 req cycles", 64'(reqCycles - reqBefore), 64'd4);
        checkVal("t4 idle fault", 64'(oFault), 64'd0);
        checkVal("t4 idle busreq", 64'(oBusReq), 64'd0);
        slaveOn = 1'b1;

        // Reset while in HI
        waitCyc = 0; loWord = 32'h1111_2222; hiWord = 32'h3333_4444;
        iMemRead = 1'b1; iAddress = 64'h30;
        @(negedge iCLK);
        @(negedge iCLK);
        checkVal("t5 in HI addr", 64'(oBusAddr), 64'h34);
        iRST = 1'b1; iMemRead = 1'b0;
        @(negedge iCLK);
        checkVal("t5 busreq", 64'(oBusReq), 64'd0);
        checkVal("t5 stall", 64'(oStall), 64'd0);
        checkVal("t5 fault", 64'(oFault), 64'd0);
        checkVal("t5 rdata", oReadData, 64'd0);
        checkVal("t5 bus outs", {31'd0, oBusWe, oBusWData}, 64'd0);
        checkVal("t5 busaddr", 64'(oBusAddr), 64'd0);
        iRST = 1'b0;
        @(negedge iCLK);
        waitCyc = 1; loWord = 32'hAAAA_0001; hiWord = 32'hBBBB_0002;
        access(1'b1, 1'b0, 64'h48, 64'h0, stall, fault, rdata);
        checkVal("t5 after stall", 64'(stall), 64'd5);
        checkVal("t5 after rdata", rdata, 64'hBBBB_0002_AAAA_0001);

        // Stray ack in IDLE, then two back-to-back loads
        strayAck = 1'b1; loWord = 32'hFFFF_FFFF; hiWord = 32'hFFFF_FFFF;
        @(negedge iCLK);
        strayAck = 1'b0;
        @(negedge iCLK);
        checkVal("t6 stray no capture", oReadData, 64'hBBBB_0002_AAAA_0001);
        waitCyc = 0; loWord = 32'h5555_6666; hiWord = 32'h7777_8888;
        access(1'b1, 1'b0, 64'h50, 64'h0, stall, fault, rdata);
        checkVal("t6 load1", rdata, 64'h7777_8888_5555_6666);
        loWord = 32'h0BAD_F00D; hiWord = 32'h1234_ABCD;
        access(1'b1, 1'b0, 64'h58, 64'h0, stall, fault, rdata);
        checkVal("t6 load2", rdata, 64'h1234_ABCD_0BAD_F00D);
        checkVal("t6 load2 stall", 64'(stall), 64'd3);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
